// File: rtl/multi_synch_edge_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_synch_edge_if
// Description : Channel bus for multi_synch_edge: async inputs, edge mode,
//               missed-clear request, and the debounced level/pulse/missed.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_synch_edge_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic [1:0]       mode;
    logic             clr_missed;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] missed;

    modport master (
        output in,
        output mode,
        output clr_missed,
        input  level,
        input  pulse,
        input  missed
    );

    modport slave (
        input  in,
        input  mode,
        input  clr_missed,
        output level,
        output pulse,
        output missed
    );
endinterface
`default_nettype wire

// File: rtl/multi_synch_edge.sv
`default_nettype none
// ============================================================================
// Module      : multi_synch_edge
// Description : Per-channel multi-flop synchroniser, debounce filter and
//               programmable-length edge pulse with sticky retrigger flag.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_synch_edge #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int FILTER    = 1,
    parameter int PULSE_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    multi_synch_edge_if.slave bus
);
    localparam int c_FC_W = $clog2(FILTER) + 1;
    localparam int c_PC_W = $clog2(PULSE_LEN) + 1;

    localparam logic [c_FC_W-1:0] c_FC_MAX  = c_FC_W'(FILTER - 1);
    localparam logic [c_PC_W-1:0] c_PC_LOAD = c_PC_W'(PULSE_LEN - 1);
    localparam logic [c_FC_W-1:0] c_FC_ONE  = c_FC_W'(1);
    localparam logic [c_PC_W-1:0] c_PC_ONE  = c_PC_W'(1);

    localparam logic [1:0] c_MODE_RISE = 2'b00;
    localparam logic [1:0] c_MODE_FALL = 2'b01;
    localparam logic [1:0] c_MODE_BOTH = 2'b10;

    logic             w_rise_en;
    logic             w_fall_en;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_pulse;
    logic [WIDTH-1:0] w_missed;

    // Mode is shared by all channels; 2'b11 leaves both enables low.
    assign w_rise_en = (bus.mode == c_MODE_RISE) || (bus.mode == c_MODE_BOTH);
    assign w_fall_en = (bus.mode == c_MODE_FALL) || (bus.mode == c_MODE_BOTH);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            logic [STAGES-1:0] r_sync;
            logic [c_FC_W-1:0] r_fc;
            logic [c_PC_W-1:0] r_pc;
            logic              r_level;
            logic              r_pulse;
            logic              r_missed;
            logic              w_sy;
            logic              w_upd;
            logic              w_qual;

            assign w_sy   = r_sync[STAGES-1];
            assign w_upd  = (w_sy != r_level) && (r_fc == c_FC_MAX);
            assign w_qual = w_upd && (w_sy ? w_rise_en : w_fall_en);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync   <= '0;
                    r_fc     <= '0;
                    r_pc     <= '0;
                    r_level  <= 1'b0;
                    r_pulse  <= 1'b0;
                    r_missed <= 1'b0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], bus.in[i]};

                    if (w_sy == r_level) begin
                        r_fc <= '0;
                    end else if (r_fc == c_FC_MAX) begin
                        r_level <= w_sy;
                        r_fc    <= '0;
                    end else begin
                        r_fc <= r_fc + c_FC_ONE;
                    end

                    // A qualifying edge always (re)loads, so a retrigger on
                    // the final pulse cycle extends without a gap.
                    if (w_qual) begin
                        r_pulse <= 1'b1;
                        r_pc    <= c_PC_LOAD;
                    end else if (r_pulse) begin
                        if (r_pc == '0) begin
                            r_pulse <= 1'b0;
                        end else begin
                            r_pc <= r_pc - c_PC_ONE;
                        end
                    end

                    if (w_qual && r_pulse) begin
                        r_missed <= 1'b1;
                    end else if (bus.clr_missed) begin
                        r_missed <= 1'b0;
                    end
                end
            end

            assign w_level[i]  = r_level;
            assign w_pulse[i]  = r_pulse;
            assign w_missed[i] = r_missed;
        end
    endgenerate

    assign bus.level  = w_level;
    assign bus.pulse  = w_pulse;
    assign bus.missed = w_missed;
endmodule
`default_nettype wire

// File: tb/tb_multi_synch_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_synch_edge
// Description : Directed self-checking bench for multi_synch_edge using a
//               default, a FILTER=4 and a PULSE_LEN=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_synch_edge;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multi_synch_edge_if #(.WIDTH(4)) a_if ();
    multi_synch_edge_if #(.WIDTH(4)) f_if ();
    multi_synch_edge_if #(.WIDTH(4)) p_if ();

    multi_synch_edge #(.WIDTH(4), .STAGES(2), .FILTER(1), .PULSE_LEN(2)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );
    multi_synch_edge #(.WIDTH(4), .STAGES(2), .FILTER(4), .PULSE_LEN(2)) u_f (
        .clk (clk),
        .rst (rst),
        .bus (f_if)
    );
    multi_synch_edge #(.WIDTH(4), .STAGES(2), .FILTER(1), .PULSE_LEN(4)) u_p (
        .clk (clk),
        .rst (rst),
        .bus (p_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_if.in = '0; a_if.mode = 2'b00; a_if.clr_missed = 1'b0;
        f_if.in = '0; f_if.mode = 2'b00; f_if.clr_missed = 1'b0;
        p_if.in = '0; p_if.mode = 2'b10; p_if.clr_missed = 1'b0;
        tick(3);
        rst = 1'b0;
        check("rst_level", a_if.level, 4'b0000);
        check("rst_pulse", a_if.pulse, 4'b0000);
        check("rst_missed", a_if.missed, 4'b0000);

        // Rise in mode 00: level/pulse after edge 3, pulse 2 cycles
        a_if.in = 4'b0001;
        tick(1); check("rise_e1_pulse", a_if.pulse, 4'b0000);
        tick(1); check("rise_e2_level", a_if.level, 4'b0000);
        tick(1); check("rise_e3_level", a_if.level, 4'b0001);
                 check("rise_e3_pulse", a_if.pulse, 4'b0001);
        tick(1); check("rise_e4_pulse", a_if.pulse, 4'b0001);
        tick(1); check("rise_e5_pulse", a_if.pulse, 4'b0000);
                 check("rise_missed", a_if.missed, 4'b0000);
        a_if.in = 4'b0000;
        tick(3); check("rise_fall_level", a_if.level, 4'b0000);
                 check("rise_fall_nopulse", a_if.pulse, 4'b0000);

        // Both-edge mode
        a_if.mode = 2'b10;
        a_if.in = 4'b0010;
        tick(3); check("both_r_level", a_if.level, 4'b0010);
                 check("both_r_p1", a_if.pulse, 4'b0010);
        tick(1); check("both_r_p2", a_if.pulse, 4'b0010);
        tick(1); check("both_r_p3", a_if.pulse, 4'b0000);
        tick(5);
        a_if.in = 4'b0000;
        tick(3); check("both_f_level", a_if.level, 4'b0000);
                 check("both_f_p1", a_if.pulse, 4'b0010);
        tick(1); check("both_f_p2", a_if.pulse, 4'b0010);
        tick(1); check("both_f_p3", a_if.pulse, 4'b0000);

        // Fall-only mode
        a_if.mode = 2'b01;
        a_if.in = 4'b0010;
        tick(3); check("fall_r_level", a_if.level, 4'b0010);
                 check("fall_r_nopulse", a_if.pulse, 4'b0000);
        tick(2); check("fall_r_nopulse2", a_if.pulse, 4'b0000);
        a_if.in = 4'b0000;
        tick(3); check("fall_f_level", a_if.level, 4'b0000);
                 check("fall_f_p1", a_if.pulse, 4'b0010);
        tick(1); check("fall_f_p2", a_if.pulse, 4'b0010);
        tick(1); check("fall_f_p3", a_if.pulse, 4'b0000);

        // Disabled mode: level tracks, no pulses
        a_if.mode = 2'b11;
        a_if.in = 4'b0010;
        tick(3); check("dis_r_level", a_if.level, 4'b0010);
                 check("dis_r_pulse", a_if.pulse, 4'b0000);
        a_if.in = 4'b0000;
        tick(3); check("dis_f_level", a_if.level, 4'b0000);
                 check("dis_f_pulse", a_if.pulse, 4'b0000);

        // Debounce FILTER=4: 3-cycle glitch rejected
        f_if.in = 4'b0100;
        tick(3);
        f_if.in = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            check("glitch_level", f_if.level, 4'b0000);
            check("glitch_pulse", f_if.pulse, 4'b0000);
            tick(1);
        end
        // 6-cycle high: level at edge 6
        f_if.in = 4'b0100;
        tick(5); check("deb_e5_level", f_if.level, 4'b0000);
        tick(1); check("deb_e6_level", f_if.level, 4'b0100);
                 check("deb_e6_pulse", f_if.pulse, 4'b0100);
        f_if.in = 4'b0000;
        tick(1); check("deb_e7_pulse", f_if.pulse, 4'b0100);
        tick(1); check("deb_e8_pulse", f_if.pulse, 4'b0000);
        tick(8); check("deb_settle_level", f_if.level, 4'b0000);

        // Retrigger PULSE_LEN=4 mode 10: 2-cycle high -> 6-cycle pulse
        p_if.in = 4'b1000;
        tick(2);
        p_if.in = 4'b0000;
        tick(1); check("rt_e3_pulse", p_if.pulse, 4'b1000);
                 check("rt_e3_missed", p_if.missed, 4'b0000);
        tick(1); check("rt_e4_pulse", p_if.pulse, 4'b1000);
        tick(1); check("rt_e5_pulse", p_if.pulse, 4'b1000);
                 check("rt_e5_missed", p_if.missed, 4'b1000);
        tick(1); check("rt_e6_pulse", p_if.pulse, 4'b1000);
        tick(1); check("rt_e7_pulse", p_if.pulse, 4'b1000);
        tick(1); check("rt_e8_pulse", p_if.pulse, 4'b1000);
        tick(1); check("rt_e9_pulse", p_if.pulse, 4'b0000);
                 check("rt_e9_missed", p_if.missed, 4'b1000);
        p_if.clr_missed = 1'b1;
        tick(1); check("rt_clr_missed", p_if.missed, 4'b0000);
        p_if.clr_missed = 1'b0;

        // Simultaneous edges on all channels
        a_if.mode = 2'b10;
        a_if.in = 4'b1111;
        tick(3); check("sim_level", a_if.level, 4'b1111);
                 check("sim_pulse", a_if.pulse, 4'b1111);
        tick(2); check("sim_pulse_end", a_if.pulse, 4'b0000);
        a_if.in = 4'b0000;
        tick(3); check("sim_fall_pulse", a_if.pulse, 4'b1111);
        tick(3); check("sim_fall_level", a_if.level, 4'b0000);

        // clr_missed on the same edge as a missed event: set wins
        p_if.in = 4'b0001;
        tick(2);
        p_if.in = 4'b0000;
        tick(2);
        p_if.clr_missed = 1'b1;
        tick(1); check("setwins_missed", p_if.missed, 4'b0001);
        p_if.clr_missed = 1'b0;
        tick(1); check("setwins_sticky", p_if.missed, 4'b0001);

        // Reset mid-pulse and mid-filter
        a_if.mode = 2'b00;
        a_if.in = 4'b0001;
        f_if.in = 4'b0001;
        tick(4); check("mid_pulse_pre", a_if.pulse, 4'b0001);
        rst = 1'b1;
        tick(1); check("mid_rst_pulse", a_if.pulse, 4'b0000);
                 check("mid_rst_level", a_if.level, 4'b0000);
                 check("mid_rst_missed", p_if.missed, 4'b0000);
                 check("mid_rst_flevel", f_if.level, 4'b0000);
        rst = 1'b0;
        tick(2); check("post_e2_pulse", a_if.pulse, 4'b0000);
        tick(1); check("post_e3_pulse", a_if.pulse, 4'b0001);
                 check("post_e3_level", a_if.level, 4'b0001);
        tick(2); check("post_e5_flevel", f_if.level, 4'b0000);
        tick(1); check("post_e6_flevel", f_if.level, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
